// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide execution unit: unit select
// code, opcode values, FSM state encoding, iteration count and small helpers.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] FU_MULDIV = 2'b10;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Even opcodes (mult, div) are the signed flavours.
  function automatic logic op_is_signed(input logic [2:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue and writeback signals between the pipeline and the multiply/divide
// unit. The pipeline side is the master, the unit is the slave.
interface ex_muldiv_if;

  logic [1:0]  is_ex_func_unit;
  logic [2:0]  is_ex_aluop;
  logic [31:0] is_ex_rega;
  logic [31:0] is_ex_regb;
  logic [4:0]  is_ex_regdest;
  logic        is_ex_writereg;
  logic        md_flush;
  logic        md_is_busy;
  logic        md_wb_valid;
  logic        md_wb_ready;
  logic [31:0] md_wb_hi;
  logic [31:0] md_wb_lo;
  logic [4:0]  md_wb_regdest;
  logic        md_wb_writereg;
  logic        md_wb_divzero;

  modport master (
    output is_ex_func_unit, is_ex_aluop, is_ex_rega, is_ex_regb,
           is_ex_regdest, is_ex_writereg, md_flush, md_wb_ready,
    input  md_is_busy, md_wb_valid, md_wb_hi, md_wb_lo,
           md_wb_regdest, md_wb_writereg, md_wb_divzero
  );

  modport slave (
    input  is_ex_func_unit, is_ex_aluop, is_ex_rega, is_ex_regb,
           is_ex_regdest, is_ex_writereg, md_flush, md_wb_ready,
    output md_is_busy, md_wb_valid, md_wb_hi, md_wb_lo,
           md_wb_regdest, md_wb_writereg, md_wb_divzero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply/divide datapath.
// Multiply: radix-2 shift-add; {hi,lo} shifts right, lo holds the multiplier.
// Divide (only when MULDIV_DIV_EN is defined): restoring shift-subtract;
// hi is the partial remainder, lo shifts the dividend out and the quotient in.
module muldiv_step (
`ifdef MULDIV_DIV_EN
  input  logic        is_div,
`endif
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] shifted;
  logic [32:0] diff;
`endif

  // Combinational step: add-and-shift, or trial-subtract-and-shift.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
    hi_next = sum[32:1];
    lo_next = {sum[0], lo[31:1]};
`ifdef MULDIV_DIV_EN
    shifted = {hi, lo[31]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      // The partial remainder is always below the divisor, so a clear
      // borrow bit means the trial subtraction fits in 32 bits.
      if (!diff[32]) begin
        hi_next = diff[31:0];
        lo_next = {lo[30:0], 1'b1};
      end else begin
        hi_next = shifted[31:0];
        lo_next = {lo[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide execution unit.
// IDLE -> RUN (32 iterations) -> FIX (sign correction) -> DONE (hold result
// until md_wb_ready). Signed operands are iterated as magnitudes and the
// result sign is applied in FIX. Divide by zero short-cuts straight to DONE.
// Build option: MULDIV_DIV_EN enables the divide datapath; without it the
// divide opcodes are still accepted and complete the next cycle with zeros.
module ex_muldiv
  import muldiv_pkg::*;
(
  input logic        clock,
  input logic        reset,
  ex_muldiv_if.slave bus
);

  state_e           state, state_next;
  logic [CNT_W-1:0] count;
  logic [31:0]      acc_hi, acc_lo, opnd_b;
  logic             neg_q;
`ifdef MULDIV_DIV_EN
  logic             op_div;
  logic             neg_r;
`endif
  logic [31:0]      step_hi, step_lo;
  logic [31:0]      fix_hi, fix_lo;
  logic [31:0]      wb_hi, wb_lo;
  logic [4:0]       wb_regdest;
  logic             wb_writereg, wb_divzero;
  logic             accept, acc_signed, acc_div, short_cut;

  // Flush wins over a same-cycle select.
  assign accept     = (state == S_IDLE) && (bus.is_ex_func_unit == FU_MULDIV)
                      && !bus.is_ex_aluop[2] && !bus.md_flush;
  assign acc_signed = op_is_signed(bus.is_ex_aluop);
  assign acc_div    = op_is_div(bus.is_ex_aluop);
`ifdef MULDIV_DIV_EN
  assign short_cut  = acc_div && (bus.is_ex_regb == 32'd0);
`else
  assign short_cut  = acc_div;
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      S_IDLE: if (accept) state_next = short_cut ? S_DONE : S_RUN;
      S_RUN:  if (count == '0) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (bus.md_wb_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.md_flush) state_next = S_IDLE;
  end

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (op_div),
`endif
    .hi      (acc_hi),
    .lo      (acc_lo),
    .opnd    (opnd_b),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign correction: 64-bit negate for multiply; quotient and remainder
  // negated independently for divide (remainder follows the dividend).
  always_comb begin
    {fix_hi, fix_lo} = neg_q ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
`ifdef MULDIV_DIV_EN
    if (op_div) begin
      fix_lo = neg_q ? (32'd0 - acc_lo) : acc_lo;
      fix_hi = neg_r ? (32'd0 - acc_hi) : acc_hi;
    end
`endif
  end

  // Operand latch at accept, iteration in RUN, result capture in FIX.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd_b      <= '0;
      neg_q       <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div      <= 1'b0;
      neg_r       <= 1'b0;
`endif
      wb_hi       <= '0;
      wb_lo       <= '0;
      wb_regdest  <= '0;
      wb_writereg <= 1'b0;
      wb_divzero  <= 1'b0;
    end else if (accept) begin
      count       <= CNT_W'(ITER - 1);
      acc_hi      <= '0;
      acc_lo      <= acc_signed ? abs32(bus.is_ex_rega) : bus.is_ex_rega;
      opnd_b      <= acc_signed ? abs32(bus.is_ex_regb) : bus.is_ex_regb;
      neg_q       <= acc_signed && (bus.is_ex_rega[31] ^ bus.is_ex_regb[31]);
`ifdef MULDIV_DIV_EN
      op_div      <= acc_div;
      neg_r       <= acc_signed && bus.is_ex_rega[31];
`endif
      wb_regdest  <= bus.is_ex_regdest;
      wb_writereg <= bus.is_ex_writereg;
      wb_divzero  <= 1'b0;
      if (short_cut) begin
`ifdef MULDIV_DIV_EN
        wb_hi      <= bus.is_ex_rega;
        wb_lo      <= '1;
        wb_divzero <= 1'b1;
`else
        wb_hi      <= '0;
        wb_lo      <= '0;
`endif
      end
    end else if (state == S_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (count != '0) count <= count - CNT_W'(1);
    end else if (state == S_FIX) begin
      wb_hi <= fix_hi;
      wb_lo <= fix_lo;
    end
  end

  assign bus.md_is_busy     = (state != S_IDLE);
  assign bus.md_wb_valid    = (state == S_DONE);
  assign bus.md_wb_hi       = wb_hi;
  assign bus.md_wb_lo       = wb_lo;
  assign bus.md_wb_regdest  = wb_regdest;
  assign bus.md_wb_writereg = wb_writereg;
  assign bus.md_wb_divzero  = wb_divzero;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for result hold, flush and mid-operation reset.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clock;
  logic reset;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model written from the arithmetic definition.
  function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dz,
                                output int lat);
    longint      sa, sb, q, r, p;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dz  = 1'b0;
    lat = ITER + 2;
    hi  = '0;
    lo  = '0;
    if (op == OP_MULT) begin
      p  = sa * sb;
      pu = p;
      hi = pu[63:32];
      lo = pu[31:0];
    end else if (op == OP_MULTU) begin
      pu = {32'd0, a} * {32'd0, b};
      hi = pu[63:32];
      lo = pu[31:0];
    end else begin
`ifdef MULDIV_DIV_EN
      if (b == 32'd0) begin
        lo  = 32'hFFFF_FFFF;
        hi  = a;
        dz  = 1'b1;
        lat = 1;
      end else if (op == OP_DIV) begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end else begin
        lo = a / b;
        hi = a % b;
      end
`else
      lat = 1;
`endif
    end
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic wr);
    bus.is_ex_func_unit = FU_MULDIV;
    bus.is_ex_aluop     = op;
    bus.is_ex_rega      = a;
    bus.is_ex_regb      = b;
    bus.is_ex_regdest   = tag;
    bus.is_ex_writereg  = wr;
    tick();
    bus.is_ex_func_unit = 2'b00;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.md_wb_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic wr,
                        input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic e_dz, input int e_lat);
    int lat;
    bit busy_ok;
    issue(op, a, b, tag, wr);
    lat     = 1;
    busy_ok = 1'b1;
    while (bus.md_wb_valid !== 1'b1 && lat < 100) begin
      if (bus.md_is_busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, e_lat);
    check({name, "_busy"}, {busy_ok, bus.md_is_busy}, 2'b11);
    check({name, "_hi"}, bus.md_wb_hi, e_hi);
    check({name, "_lo"}, bus.md_wb_lo, e_lo);
    check({name, "_divzero"}, bus.md_wb_divzero, e_dz);
    check({name, "_tag"}, {bus.md_wb_regdest, bus.md_wb_writereg}, {tag, wr});
    bus.md_wb_ready = 1'b1;
    tick();
    bus.md_wb_ready = 1'b0;
    check({name, "_released"}, {bus.md_wb_valid, bus.md_is_busy}, 2'b00);
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic        ed;
    logic [2:0]  op;
    int          elat, lat;
    bit          seen;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
    vecs[3] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
`ifdef MULDIV_DIV_EN
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 1};
    vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[7] = '{OP_DIVU,  32'd7,         32'hFFFF_FFFF, 32'd7,         32'd0,         1'b0, 34};
`else
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'd0, 32'd0, 1'b0, 1};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd0,         32'd0, 32'd0, 1'b0, 1};
    vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1};
    vecs[7] = '{OP_DIVU,  32'd7,         32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1};
`endif

    bus.is_ex_func_unit = 2'b00;
    bus.is_ex_aluop     = 3'b000;
    bus.is_ex_rega      = '0;
    bus.is_ex_regb      = '0;
    bus.is_ex_regdest   = '0;
    bus.is_ex_writereg  = 1'b0;
    bus.md_flush        = 1'b0;
    bus.md_wb_ready     = 1'b0;
    reset               = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_busy",     bus.md_is_busy,     0);
    check("rst_valid",    bus.md_wb_valid,    0);
    check("rst_hi",       bus.md_wb_hi,       0);
    check("rst_lo",       bus.md_wb_lo,       0);
    check("rst_regdest",  bus.md_wb_regdest,  0);
    check("rst_writereg", bus.md_wb_writereg, 0);
    check("rst_divzero",  bus.md_wb_divzero,  0);
    reset = 1'b1;
    tick();

    // Reserved opcode is ignored.
    issue(3'b100, 32'd5, 32'd6, 5'd1, 1'b1);
    check("reserved_ignored", bus.md_is_busy, 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             5'(i + 3), i[0], vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
    end

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model(op, a, b, eh, el, ed, elat);
      run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), eh, el, ed, elat);
    end

    // Result held in DONE while ready is low; selects meanwhile are ignored.
    model(OP_MULT, 32'd123456, 32'hFFFF_FCEB, eh, el, ed, elat);
    issue(OP_MULT, 32'd123456, 32'hFFFF_FCEB, 5'd11, 1'b1);
    wait_valid(lat);
    check("hold_latency", lat, 34);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), bus.md_wb_valid, 1);
      check($sformatf("hold%0d_hi", k), bus.md_wb_hi, eh);
      check($sformatf("hold%0d_lo", k), bus.md_wb_lo, el);
      check($sformatf("hold%0d_tag", k), bus.md_wb_regdest, 5'd11);
      if (k == 1) begin
        bus.is_ex_func_unit = FU_MULDIV;
        bus.is_ex_aluop     = OP_MULTU;
        bus.is_ex_rega      = 32'd5;
        bus.is_ex_regb      = 32'd6;
        bus.is_ex_regdest   = 5'd9;
      end
      if (k == 3) bus.is_ex_func_unit = 2'b00;
      tick();
    end
    bus.is_ex_func_unit = FU_MULDIV;
    bus.is_ex_aluop     = OP_MULTU;
    bus.is_ex_rega      = 32'd1000;
    bus.is_ex_regb      = 32'd1000;
    bus.is_ex_regdest   = 5'd7;
    bus.is_ex_writereg  = 1'b1;
    bus.md_wb_ready     = 1'b1;
    tick();
    bus.md_wb_ready = 1'b0;
    check("release_idle_busy", bus.md_is_busy, 0);
    tick();
    bus.is_ex_func_unit = 2'b00;
    check("release_accept_busy", bus.md_is_busy, 1);
    wait_valid(lat);
    check("second_latency", lat, 34);
    check("second_hi", bus.md_wb_hi, 0);
    check("second_lo", bus.md_wb_lo, 32'd1000000);
    check("second_tag", bus.md_wb_regdest, 5'd7);
    bus.md_wb_ready = 1'b1;
    tick();
    bus.md_wb_ready = 1'b0;

    // Flush in the middle of RUN.
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2, 1'b1);
    repeat (9) tick();
    bus.md_flush = 1'b1;
    tick();
    bus.md_flush = 1'b0;
    check("flush_busy",  bus.md_is_busy,  0);
    check("flush_valid", bus.md_wb_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      if (bus.md_wb_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_valid", seen, 0);

    // Flush beats a same-cycle select.
    bus.md_flush = 1'b1;
    issue(OP_MULT, 32'd3, 32'd4, 5'd1, 1'b1);
    bus.md_flush = 1'b0;
    check("flush_blocks_accept", bus.md_is_busy, 0);

    // Recovery after flush, leaving non-zero results in the output registers.
    run_op("post_flush", OP_MULTU, 32'hFFFF_FFFF, 32'd3, 5'd30, 1'b1,
           32'd2, 32'hFFFF_FFFD, 1'b0, 34);

    // Reset during RUN clears everything at once and abandons the operation.
    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 1'b1);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("midrst_busy",     bus.md_is_busy,     0);
    check("midrst_valid",    bus.md_wb_valid,    0);
    check("midrst_hi",       bus.md_wb_hi,       0);
    check("midrst_lo",       bus.md_wb_lo,       0);
    check("midrst_regdest",  bus.md_wb_regdest,  0);
    check("midrst_writereg", bus.md_wb_writereg, 0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      if (bus.md_wb_valid || bus.md_is_busy) seen = 1'b1;
      tick();
    end
    check("midrst_no_valid", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide: clock  input  1  rising-edge clock.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: is_ex_func_unit  input  2  functional-unit select; 2'b10 selects this block.
REQ-004 SHALL provide: is_ex_aluop  input  3  opcode: 000 mult, 001 multu, 010 div, 011 divu; 1xx reserved.
REQ-005 SHALL provide: is_ex_rega, is_ex_regb  input  32 each  operand A (multiplicand/dividend), operand B (multiplier/divisor).
REQ-006 SHALL provide: is_ex_regdest  input  5, is_ex_writereg  input  1  destination tag, passed through to writeback.
REQ-007 SHALL provide: md_flush  input  1  kill any operation in flight.
REQ-008 SHALL provide: md_is_busy  output  1  unit occupied; issue must not select the unit while high.
REQ-009 SHALL provide: md_wb_valid  output  1, md_wb_ready  input  1  result handshake.
REQ-010 SHALL provide: md_wb_hi, md_wb_lo  output  32 each; md_wb_regdest  output  5; md_wb_writereg  output  1; md_wb_divzero  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-012 Accept condition: state IDLE, is_ex_func_unit==2'b10, aluop not reserved; the block latches operands, opcode and tag, and moves to RUN.
REQ-013 Selection while not IDLE, or with a reserved aluop, SHALL be ignored with no state change.
REQ-014 md_is_busy SHALL equal (state != IDLE).
REQ-015 Signed operations SHALL latch absolute values plus result-sign flags; unsigned operations latch operands unchanged.
REQ-016 RUN SHALL perform exactly 32 iterations using a 5-bit down-counter: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-017 After the final iteration the FSM SHALL go to FIX, apply two's-complement sign correction, then go to DONE.
REQ-018 Latency: for an accept at the edge ending cycle N, md_wb_valid SHALL be high in cycle N+34.
REQ-019 Multiply result SHALL be the 64-bit product, with hi = bits[63:32] and lo = bits[31:0].
REQ-020 Divide result SHALL be lo = quotient and hi = remainder; the remainder takes the sign of the dividend.
REQ-021 Divisor zero SHALL be detected at accept: DONE the next cycle, lo = 32'hFFFF_FFFF, hi = dividend, md_wb_divzero = 1.
REQ-022 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield lo = 32'h8000_0000, hi = 0, divzero = 0.
REQ-023 In DONE, outputs SHALL hold stable with md_wb_valid high until md_wb_ready is sampled high, then return to IDLE.
REQ-024 A new operation SHALL NOT be accepted in the DONE-to-IDLE cycle; the earliest accept is the following cycle.
REQ-025 is_ex_writereg=0 SHALL still produce a full result handshake.
REQ-026 md_flush SHALL return the FSM to IDLE at the next edge from any state, deasserting md_wb_valid; flush has priority over accept and over ready.

Reset
REQ-027 While reset is low: state IDLE, counter 0, md_is_busy 0, md_wb_valid 0, md_wb_hi/lo 0, md_wb_regdest 0, md_wb_writereg 0, md_wb_divzero 0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no result handshake.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: divide datapath and opcodes 010/011 SHALL be present as specified.
REQ-030 Macro MULDIV_DIV_EN undefined: no divide hardware; opcodes 010/011 SHALL be accepted and reach DONE the next cycle with hi = lo = 0 and divzero = 0.

Structure
REQ-031 Package muldiv_pkg SHALL hold the aluop codes, the FU code 2'b10, the FSM state encoding and ITER = 32.
REQ-032 The per-iteration add/subtract-and-shift step SHALL be one sub-module, muldiv_step; the FSM, counter, sign handling and handshake remain in ex_muldiv.

Verification
REQ-033 multu 32'hFFFF_FFFF x 32'hFFFF_FFFF -> valid at N+34, hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
REQ-034 mult -7 x 3 -> hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFEB; busy high from N+1 to valid.
REQ-035 div -7 / 2 -> lo = 32'hFFFF_FFFD, hi = 32'hFFFF_FFFF; divu 100 / 0 -> next-cycle valid, lo = FFFF_FFFF, hi = 100, divzero = 1.
REQ-036 Hold md_wb_ready low 5 cycles in DONE -> outputs stable; a second select during that time is ignored; ready high -> IDLE, accept two cycles later.
REQ-037 md_flush at RUN iteration 10 -> IDLE next cycle, no valid; reset low at RUN -> all outputs 0 immediately.
